imem_uart_loader: RTL and testbench
===================================

# imem_uart_loader

Boot loader upstream of the core's instruction memory. Receives a program image over a UART RX line, writes it word-by-word into the instruction memory write port, and holds the core in reset until the image is complete and valid. Releases the core on success; flags an error and keeps the core held on a malformed image.

## Interface

Parameters:
- CLK_FREQ, 27: system clock in MHz.
- BAUD, 115200: UART bit rate.
- ADDR_WIDTH, 10: instruction memory word-address width; capacity 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- uart_rx  in  1  serial input, idle high, 8N1, LSB first.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_WIDTH  word address of the write.
- imem_wdata  out  32  instruction word.
- core_rst_o  out  1  held high until load completes; drives the core's rst_i.
- done  out  1  image loaded and accepted; sticky until reset.
- err  out  1  framing, length or checksum failure; sticky until the next sync byte.

## Operation

- Frame: sync byte 0xA5, word count N (2 bytes, little-endian), N words (4 bytes each, little-endian), checksum byte.
- Checksum: 8-bit XOR of the two length bytes and all 4N data bytes.
- States: IDLE (wait sync) -> LEN0 -> LEN1 -> DATA -> CSUM -> DONE; any state except DONE -> ERR on failure.
- IDLE: non-0xA5 bytes discarded. 0xA5 -> LEN0; clears err, word index and checksum accumulator.
- LEN1: N == 0 -> CSUM; N > 2^ADDR_WIDTH -> ERR; otherwise -> DATA.
- DATA: bytes shifted into a 32-bit assembler; the 4th byte issues a write at address = word index, then the index increments. After word N-1 -> CSUM.
- CSUM: match -> DONE; mismatch -> ERR.
- DONE: done=1, core_rst_o=0; further RX bytes ignored until rst_i.
- ERR: err=1, core_rst_o=1; only 0xA5 restarts (-> LEN0). Words already written are not rolled back.
- A framing error (stop bit sampled 0) in any state except DONE -> ERR; the byte is discarded.
- Bit divisor = CLK_FREQ*1_000_000/BAUD, truncated (27 MHz/115200 -> 234).

## Timing

- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, core_rst_o=1, done=0, err=0; FSM in IDLE; receiver idle.
- RX: 2-flop synchronizer on uart_rx; falling edge starts a frame; start bit re-checked at half-bit (high there -> glitch, return to idle); data bits sampled at bit centres; byte valid as a one-cycle pulse at the stop-bit centre.
- imem_we asserts the cycle after the byte-valid pulse of a word's 4th byte; addr and data are stable on that cycle.
- core_rst_o falls and done rises on the same cycle, one cycle after the checksum byte-valid pulse (after the last-word write when the checksum is compiled out).
- rst_i mid-load: immediate return to reset values; partial image remains in memory; core held.

## Configuration

- LOADER_CHECKSUM_EN defined: CSUM state present; checksum byte required and checked.
- Undefined: no checksum byte, no accumulator; DATA (or LEN1 with N == 0) goes directly to DONE; err is raised only by framing or length failures.

## Structure

- Shared package imem_loader_pkg: sync byte constant 0xA5, FSM state enum, and the divisor expression.
- Sub-module uart_rx (CLK_FREQ, BAUD): synchronizer, bit timing, byte shift, byte-valid and frame-error outputs. The loader FSM, word assembly and checksum logic sit in the top.

## Test plan

- Image A5 02 00 13 00 00 00 93 00 10 00 + checksum 0x92 -> writes 0x00000013 @0, 0x00100093 @1; done=1, core_rst_o=0.
- Same image with checksum 0x00 -> err=1, core_rst_o=1, done=0; resending the correct frame -> done=1.
- Leading garbage 0x55 0xFF, then a valid N=0 frame (A5 00 00 00) -> no imem_we; done=1.
- N=0x0401 with ADDR_WIDTH=10 -> err=1 after LEN1; no writes.
- Stop bit forced low on the 3rd data byte -> err=1; no write for that word.
- rst_i pulsed after 5 of 8 data bytes -> outputs return to reset values; the following full frame loads normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module : imem_loader_pkg
// Brief  : Shared constants for the UART instruction-memory boot loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t ST_IDLE = 3'd0;
  localparam loader_state_t ST_LEN0 = 3'd1;
  localparam loader_state_t ST_LEN1 = 3'd2;
  localparam loader_state_t ST_DATA = 3'd3;
  localparam loader_state_t ST_CSUM = 3'd4;
  localparam loader_state_t ST_DONE = 3'd5;
  localparam loader_state_t ST_ERR  = 3'd6;

  // Clock cycles per UART bit, truncated.
  function automatic int unsigned bit_divisor(input int unsigned clk_mhz,
                                              input int unsigned baud);
    return (clk_mhz * 32'd1_000_000) / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_uart_loader_uart_rx.sv
// ============================================================================
// Module : uart_rx
// Brief  : 8N1 UART receiver with synchronizer, glitch-checked start bit,
//          byte-valid and frame-error pulses at the stop-bit centre.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx
  import imem_loader_pkg::*;
#(
  parameter int CLK_FREQ = 27,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned DIV  = bit_divisor(CLK_FREQ, BAUD);
  localparam int unsigned HALF = DIV / 2;
  localparam int          CW   = $clog2(DIV);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          meta_q, sync_q, prev_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  logic w_full_bit, w_half_bit;

  assign w_full_bit = (cnt_q == CW'(DIV - 1));
  assign w_half_bit = (cnt_q == CW'(HALF - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (prev_q && !sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (w_half_bit) begin
          cnt_d   = '0;
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (w_full_bit) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (w_full_bit) begin
          state_d = RX_IDLE;
          valid_d = sync_q;
          ferr_d  = !sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rx_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

`default_nettype wire

// File: rtl/imem_uart_loader.sv
// ============================================================================
// Module : imem_uart_loader
// Brief  : UART boot loader writing a framed image into instruction memory and
//          holding the core in reset until it is complete. Optional checksum
//          stage enabled by defining LOADER_CHECKSUM_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int CLK_FREQ   = 27,
  parameter int BAUD       = 115200,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  uart_rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_o,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CAP = 32'd1 << ADDR_WIDTH;

  logic [7:0] w_rx_byte;
  logic       w_rx_valid, w_rx_ferr;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_uart_rx (
    .clk          (clk),
    .rst_i        (rst_i),
    .rx_i         (uart_rx),
    .byte_o       (w_rx_byte),
    .byte_valid_o (w_rx_valid),
    .frame_err_o  (w_rx_ferr)
  );

  loader_state_t         state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           idx_q, idx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           asm_q, asm_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  core_rst_q, core_rst_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic [15:0] w_len;
  logic [15:0] w_idx_next;

  assign w_len      = {w_rx_byte, len_lo_q};
  assign w_idx_next = idx_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;
    core_rst_d = core_rst_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (w_rx_ferr && state_q != ST_DONE) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
    end else if (w_rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
      csum_d = csum_q ^ w_rx_byte;
`endif
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (w_rx_byte == SYNC_BYTE) begin
            state_d = ST_LEN0;
            err_d   = 1'b0;
            idx_d   = '0;
            bcnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
          end
        end
        ST_LEN0: begin
          len_lo_d = w_rx_byte;
          state_d  = ST_LEN1;
        end
        ST_LEN1: begin
          len_d = w_len;
          if (w_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d    = ST_DONE;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
`endif
          end else if ({16'd0, w_len} > CAP) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          // Bytes arrive little-endian; the first three wait in asm_q.
          asm_d  = {w_rx_byte, asm_q[23:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = idx_q[ADDR_WIDTH-1:0];
            wdata_d = {w_rx_byte, asm_q};
            idx_d   = w_idx_next;
            if (w_idx_next == len_q) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d    = ST_DONE;
              done_d     = 1'b1;
              core_rst_d = 1'b0;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (w_rx_byte == csum_q) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst_o = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_uart_loader.sv
// ============================================================================
// Module : tb_imem_uart_loader
// Brief  : Self-checking bench for imem_uart_loader (honours LOADER_CHECKSUM_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imem_uart_loader;

  localparam int CLK_FREQ = 1;
  localparam int BAUD     = 125000;  // 8 clocks per bit
  localparam int AW       = 4;
  localparam int BIT_NS   = 80;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          uart_rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_o, done, err;

  always #5 clk = ~clk;

  imem_uart_loader #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .uart_rx    (uart_rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_o (core_rst_o),
    .done       (done),
    .err        (err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] words [16];
  int          wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(int'(imem_addr));
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk);
    uart_rx = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      #BIT_NS;
    end
    uart_rx = bad_stop ? 1'b0 : 1'b1;
    #BIT_NS;
    uart_rx = 1'b1;
    #BIT_NS;
  endtask

  // Full frame: sync, N (little-endian), n_words words from words[], checksum.
  task automatic send_frame(input int n_field, input int n_words, input bit good_csum);
    logic [7:0] cs;
    logic [7:0] b;
    cs = n_field[7:0] ^ n_field[15:8];
    send_byte(8'hA5, 1'b0);
    send_byte(n_field[7:0], 1'b0);
    send_byte(n_field[15:8], 1'b0);
    for (int w = 0; w < n_words; w++) begin
      for (int k = 0; k < 4; k++) begin
        b  = words[w][8*k +: 8];
        cs = cs ^ b;
        send_byte(b, 1'b0);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(good_csum ? cs : ~cs, 1'b0);
`else
    if (!good_csum) cs = ~cs;
`endif
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", imem_we); end
    n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_checks++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
    n_checks++; if (core_rst_o !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: got %b want 1", core_rst_o); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    do_reset();
  endtask

  task automatic test_spec_image();
    do_reset();
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    send_frame(2, 2, 1'b1);
    n_checks++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL spec_write_count: got %0d want 2", wr_addr_q.size()); end
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      n_checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== words[i]) begin
        n_fail++; $display("FAIL spec_write%0d: got %0d/%h want %0d/%h", i, wr_addr_q[i], wr_data_q[i], i, words[i]);
      end
    end
    n_checks++; if ({done, err, core_rst_o} !== 3'b100) begin n_fail++; $display("FAIL spec_status: got %b want 100", {done, err, core_rst_o}); end
    // DONE ignores further traffic.
    wr_addr_q.delete(); wr_data_q.delete();
    words[0] = 32'hDEAD_BEEF;
    send_frame(1, 1, 1'b1);
    n_checks++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL done_sticky_writes: got %0d want 0", wr_addr_q.size()); end
    n_checks++; if ({done, err, core_rst_o} !== 3'b100) begin n_fail++; $display("FAIL done_sticky_status: got %b want 100", {done, err, core_rst_o}); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    do_reset();
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    send_frame(2, 2, 1'b0);
    n_checks++; if ({done, err, core_rst_o} !== 3'b011) begin n_fail++; $display("FAIL csum_bad_status: got %b want 011", {done, err, core_rst_o}); end
    n_checks++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL csum_bad_writes: got %0d want 2", wr_addr_q.size()); end
    wr_addr_q.delete(); wr_data_q.delete();
    send_frame(2, 2, 1'b1);
    n_checks++; if ({done, err, core_rst_o} !== 3'b100) begin n_fail++; $display("FAIL csum_retry_status: got %b want 100", {done, err, core_rst_o}); end
    n_checks++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL csum_retry_writes: got %0d want 2", wr_addr_q.size()); end
  endtask
`endif

  task automatic test_garbage_empty();
    do_reset();
    send_byte(8'h55, 1'b0);
    send_byte(8'hFF, 1'b0);
    n_checks++; if ({done, err, core_rst_o} !== 3'b001) begin n_fail++; $display("FAIL garbage_status: got %b want 001", {done, err, core_rst_o}); end
    send_frame(0, 0, 1'b1);
    n_checks++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL empty_writes: got %0d want 0", wr_addr_q.size()); end
    n_checks++; if ({done, err, core_rst_o} !== 3'b100) begin n_fail++; $display("FAIL empty_status: got %b want 100", {done, err, core_rst_o}); end
  endtask

  task automatic test_length();
    do_reset();
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h04, 1'b0);
    repeat (4) @(negedge clk);
    n_checks++; if ({done, err, core_rst_o} !== 3'b011) begin n_fail++; $display("FAIL len_0401_status: got %b want 011", {done, err, core_rst_o}); end
    // One word beyond capacity.
    send_byte(8'hA5, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h00, 1'b0);
    repeat (4) @(negedge clk);
    n_checks++; if ({done, err, core_rst_o} !== 3'b011) begin n_fail++; $display("FAIL len_cap_plus1_status: got %b want 011", {done, err, core_rst_o}); end
    n_checks++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL len_err_writes: got %0d want 0", wr_addr_q.size()); end
    // Exactly full capacity, restarted from the error state.
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    send_frame(16, 16, 1'b1);
    n_checks++; if (wr_addr_q.size() != 16) begin n_fail++; $display("FAIL len_cap_count: got %0d want 16", wr_addr_q.size()); end
    for (int i = 0; i < 16 && i < wr_addr_q.size(); i++) begin
      n_checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== words[i]) begin
        n_fail++; $display("FAIL len_cap_write%0d: got %0d/%h want %0d/%h", i, wr_addr_q[i], wr_data_q[i], i, words[i]);
      end
    end
    n_checks++; if ({done, err, core_rst_o} !== 3'b100) begin n_fail++; $display("FAIL len_cap_status: got %b want 100", {done, err, core_rst_o}); end
  endtask

  task automatic test_frame_error();
    do_reset();
    words[0] = $urandom;
    words[1] = $urandom;
    send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(words[0][7:0], 1'b0);
    send_byte(words[0][15:8], 1'b0);
    send_byte(words[0][23:16], 1'b1);
    repeat (4) @(negedge clk);
    n_checks++; if ({done, err, core_rst_o} !== 3'b011) begin n_fail++; $display("FAIL ferr_status: got %b want 011", {done, err, core_rst_o}); end
    n_checks++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL ferr_writes: got %0d want 0", wr_addr_q.size()); end
    send_frame(2, 2, 1'b1);
    n_checks++; if ({done, err, core_rst_o} !== 3'b100) begin n_fail++; $display("FAIL ferr_retry_status: got %b want 100", {done, err, core_rst_o}); end
    n_checks++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL ferr_retry_writes: got %0d want 2", wr_addr_q.size()); end
  endtask

  task automatic test_reset_midload();
    do_reset();
    words[0] = $urandom;
    words[1] = $urandom;
    send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    for (int k = 0; k < 5; k++) send_byte(words[k / 4][8*(k % 4) +: 8], 1'b0);
    n_checks++; if (wr_addr_q.size() != 1) begin n_fail++; $display("FAIL midload_partial_writes: got %0d want 1", wr_addr_q.size()); end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if ({imem_we, imem_addr, imem_wdata, done, err, core_rst_o} !== {1'b0, {AW{1'b0}}, 32'h0, 3'b001}) begin
      n_fail++; $display("FAIL midload_reset_values: got we=%b addr=%h wdata=%h status=%b want 0/0/0/001",
                         imem_we, imem_addr, imem_wdata, {done, err, core_rst_o});
    end
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    wr_addr_q.delete(); wr_data_q.delete();
    words[0] = $urandom;
    words[1] = $urandom;
    send_frame(2, 2, 1'b1);
    n_checks++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL midload_reload_count: got %0d want 2", wr_addr_q.size()); end
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      n_checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== words[i]) begin
        n_fail++; $display("FAIL midload_write%0d: got %0d/%h want %0d/%h", i, wr_addr_q[i], wr_data_q[i], i, words[i]);
      end
    end
    n_checks++; if ({done, err, core_rst_o} !== 3'b100) begin n_fail++; $display("FAIL midload_status: got %b want 100", {done, err, core_rst_o}); end
  endtask

  task automatic test_random_images();
    int         n;
    int         g;
    logic [7:0] gb;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) words[i] = $urandom;
      g = $urandom_range(0, 3);
      for (int i = 0; i < g; i++) begin
        gb = 8'($urandom_range(0, 255));
        if (gb == 8'hA5) gb = 8'h5A;
        send_byte(gb, 1'b0);
      end
      send_frame(n, n, 1'b1);
      n_checks++; if (wr_addr_q.size() != n) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", it, wr_addr_q.size(), n); end
      for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
        n_checks++;
        if (wr_addr_q[i] != i || wr_data_q[i] !== words[i]) begin
          n_fail++; $display("FAIL rand%0d_write%0d: got %0d/%h want %0d/%h", it, i, wr_addr_q[i], wr_data_q[i], i, words[i]);
        end
      end
      n_checks++; if ({done, err, core_rst_o} !== 3'b100) begin n_fail++; $display("FAIL rand%0d_status: got %b want 100", it, {done, err, core_rst_o}); end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spec_image();
`ifdef LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_garbage_empty();
    test_length();
    test_frame_error();
    test_reset_midload();
    test_random_images();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
